// File: rtl/alu_pkg.sv
// Shared ALU function-select codes and the multiply sequencer state encoding.
package alu_pkg;

  localparam logic [4:0] FS_PASSA16 = 5'b10000;
  localparam logic [4:0] FS_ADD16   = 5'b10100;
  localparam logic [4:0] FS_LSL16   = 5'b11011;
  localparam logic [4:0] FS_LSR16   = 5'b11100;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TEST  = 3'd1,
    ADD   = 3'd2,
    SHL   = 3'd3,
    SHR   = 3'd4,
    FINAL = 3'd5,
    DONE  = 3'd6
  } mul_state_t;

endpackage

// File: rtl/alu_multiply_sequencer.sv
// Owns the shared 16-bit ALU: forwards external requests when idle, otherwise
// drives it through an unsigned shift-and-add multiply of OpA by OpB.
module alu_multiply_sequencer
  import alu_pkg::*;
#(
  parameter int OP_WIDTH   = 8,
  parameter int ITER_LIMIT = OP_WIDTH
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic [OP_WIDTH-1:0] OpA,
  input  logic [OP_WIDTH-1:0] OpB,
  output logic                Busy,
  output logic                Done,
  output logic [15:0]         Product,
  input  logic [15:0]         Ext_A,
  input  logic [15:0]         Ext_B,
  input  logic [4:0]          Ext_FunSel,
  input  logic                Ext_WF,
  output logic [15:0]         ALU_A,
  output logic [15:0]         ALU_B,
  output logic [4:0]          ALU_FunSel,
  output logic                ALU_WF,
  input  logic [15:0]         ALU_Out
);

  mul_state_t  state;
  logic [15:0] acc;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic [3:0]  cnt;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      Product <= '0;
      Done    <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            acc    <= '0;
            mcand  <= 16'(OpA);
            mplier <= 16'(OpB);
            cnt    <= '0;
            Busy   <= 1'b1;
            state  <= TEST;
          end
        end
        TEST: begin
          // Stop as soon as the multiplier runs out of set bits.
          if (mplier == 16'd0 || cnt == 4'(ITER_LIMIT))
            state <= FINAL;
          else if (mplier[0])
            state <= ADD;
          else
            state <= SHL;
        end
        ADD: begin
          acc   <= ALU_Out;
          state <= SHL;
        end
        SHL: begin
          mcand <= ALU_Out;
          state <= SHR;
        end
        SHR: begin
          mplier <= ALU_Out;
          cnt    <= cnt + 4'd1;
          state  <= TEST;
        end
        FINAL: begin
          Product <= acc;
          Done    <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Busy states default to a flag-less pass of ACC; each step overrides what it needs.
  always_comb begin
    ALU_A      = acc;
    ALU_B      = 16'd0;
    ALU_FunSel = FS_PASSA16;
    ALU_WF     = 1'b0;
    case (state)
      IDLE: begin
        ALU_A      = Ext_A;
        ALU_B      = Ext_B;
        ALU_FunSel = Ext_FunSel;
        ALU_WF     = Ext_WF;
      end
      ADD: begin
        ALU_B      = mcand;
        ALU_FunSel = FS_ADD16;
      end
      SHL: begin
        ALU_A      = mcand;
        ALU_FunSel = FS_LSL16;
      end
      SHR: begin
        ALU_A      = mplier;
        ALU_FunSel = FS_LSR16;
      end
      FINAL: begin
        ALU_WF = 1'b1;
      end
      default: begin
        ALU_A = acc;
      end
    endcase
  end

endmodule
